// File: rtl/tip_hello_sram_bist_axi.sv
`default_nettype none
// ============================================================================
// Module   : tip_hello_sram_bist_axi
// Purpose  : AXI4 master BIST engine for the TIP_HELLO 128-bit SRAM slave.
//            On an accepted start it writes a deterministic pattern over a
//            range of 16-byte beats using INCR bursts, then reads the range
//            back and compares every beat.
//            It reports pass/fail, a saturating error count and the byte
//            address of the first failing beat.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   start_i                1-cycle start pulse, ignored while busy
//   cfg_base_i             byte base address (bits [3:0] forced to zero)
//   cfg_num_beats_i        number of 16-byte beats to test
//   cfg_seed_i             pattern seed
//   busy_o / done_o        test in progress / 1-cycle end-of-test pulse
//   pass_o                 result, held from done until the next start
//   err_count_o            saturating count of failing beats
//   first_fail_addr_o      byte address of the first failing beat
//   txaw* txw* txb*        AXI4 write address / data / response channels
//   txar* txr*             AXI4 read address / data channels
// Configuration macro
//   TIP_HELLO_BIST_LFSR_EN defined  : word(k) = {4{L_k}} from a 32-bit
//                                     Galois LFSR, x^32+x^22+x^2+x+1
//   TIP_HELLO_BIST_LFSR_EN undefined: word(k) = {4{seed ^ k}}
// ============================================================================
module tip_hello_sram_bist_axi #(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 128,
    parameter int BW_AXI_TID = 4,
    parameter int BURST_LEN  = 16,
    parameter int BW_COUNT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [BW_ADDR-1:0]    cfg_base_i,
    input  logic [BW_COUNT-1:0]   cfg_num_beats_i,
    input  logic [31:0]           cfg_seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [BW_COUNT-1:0]   err_count_o,
    output logic [BW_ADDR-1:0]    first_fail_addr_o,
    // write address channel
    output logic                  txawvalid_o,
    input  logic                  txawready_i,
    output logic [BW_AXI_TID-1:0] txawid_o,
    output logic [BW_ADDR-1:0]    txawaddr_o,
    output logic [7:0]            txawlen_o,
    output logic [2:0]            txawsize_o,
    output logic [1:0]            txawburst_o,
    // write data channel
    output logic                  txwvalid_o,
    input  logic                  txwready_i,
    output logic [BW_DATA-1:0]    txwdata_o,
    output logic [BW_DATA/8-1:0]  txwstrb_o,
    output logic                  txwlast_o,
    // write response channel
    input  logic                  txbvalid_i,
    output logic                  txbready_o,
    input  logic [BW_AXI_TID-1:0] txbid_i,
    input  logic [1:0]            txbresp_i,
    // read address channel
    output logic                  txarvalid_o,
    input  logic                  txarready_i,
    output logic [BW_AXI_TID-1:0] txarid_o,
    output logic [BW_ADDR-1:0]    txaraddr_o,
    output logic [7:0]            txarlen_o,
    output logic [2:0]            txarsize_o,
    output logic [1:0]            txarburst_o,
    // read data channel
    input  logic                  txrvalid_i,
    output logic                  txrready_o,
    input  logic [BW_AXI_TID-1:0] txrid_i,
    input  logic [BW_DATA-1:0]    txrdata_i,
    input  logic [1:0]            txrresp_i,
    input  logic                  txrlast_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_AW   = 3'd1;
    localparam logic [2:0] c_W    = 3'd2;
    localparam logic [2:0] c_B    = 3'd3;
    localparam logic [2:0] c_AR   = 3'd4;
    localparam logic [2:0] c_R    = 3'd5;
    localparam logic [2:0] c_FIN  = 3'd6;

    localparam logic [BW_COUNT-1:0] c_BURST     = BW_COUNT'(BURST_LEN);
    localparam logic [BW_COUNT-1:0] c_ONE       = BW_COUNT'(1);
    localparam logic [1:0]          c_OKAY      = 2'b00;
    localparam logic [1:0]          c_INCR      = 2'b01;
    localparam logic [2:0]          c_SIZE_16B  = 3'd4;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]          state_q;
    logic [2:0]          state_d;
    logic [BW_ADDR-1:0]  base_q;      // 16-byte aligned base
    logic [BW_COUNT-1:0] num_q;       // total beats requested
    logic [31:0]         seed_q;      // seed (LFSR build: normalised L_0)
    logic [BW_COUNT-1:0] issued_q;    // beats completed before current burst
    logic [BW_COUNT-1:0] beat_q;      // beat index within current burst
    logic [BW_COUNT-1:0] err_q;
    logic [BW_ADDR-1:0]  ffa_q;
    logic                pass_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [BW_COUNT-1:0] w_remaining;
    logic [BW_COUNT-1:0] w_burst;
    logic [BW_COUNT-1:0] w_idx;
    logic                w_last_beat;
    logic                w_more;
    logic [BW_ADDR-1:0]  w_burst_addr;
    logic [BW_ADDR-1:0]  w_beat_addr;
    logic [31:0]         w_word;
    logic [BW_DATA-1:0]  w_pattern;
    logic                w_start;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_r_hs;
    logic                w_r_err;
    logic                w_b_err;
    logic                w_err;
    logic [BW_ADDR-1:0]  w_err_addr;
    logic                w_unused;

    assign w_remaining  = num_q - issued_q;
    assign w_burst      = (w_remaining > c_BURST) ? c_BURST : w_remaining;
    assign w_idx        = issued_q + beat_q;
    assign w_last_beat  = (beat_q == (w_burst - c_ONE));
    assign w_more       = ((issued_q + w_burst) < num_q);
    assign w_burst_addr = base_q + (BW_ADDR'(issued_q) << 4);
    assign w_beat_addr  = base_q + (BW_ADDR'(w_idx) << 4);

`ifdef TIP_HELLO_BIST_LFSR_EN
    // Galois LFSR, left-shifting form; feedback taps x^22, x^2, x^1, x^0.
    localparam logic [31:0] c_POLY = 32'h0040_0007;

    logic [31:0] lfsr_q;
    logic [31:0] w_lfsr_next;

    assign w_lfsr_next = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? c_POLY : 32'h0);
    assign w_word      = lfsr_q;
`else
    assign w_word      = seed_q ^ 32'(w_idx);
`endif

    assign w_pattern  = {4{w_word}};

    assign w_start    = (state_q == c_IDLE) && start_i;
    assign w_w_hs     = (state_q == c_W)  && txwready_i;
    assign w_b_hs     = (state_q == c_B)  && txbvalid_i;
    assign w_r_hs     = (state_q == c_R)  && txrvalid_i;

    // A beat fails on data mismatch, a non-OKAY response, or an rlast that
    // does not line up with the beat counter; each failing beat counts once.
    assign w_r_err    = w_r_hs && ((txrdata_i != w_pattern) ||
                                   (txrresp_i != c_OKAY)    ||
                                   (txrlast_i != w_last_beat));
    assign w_b_err    = w_b_hs && (txbresp_i != c_OKAY);
    assign w_err      = w_r_err || w_b_err;
    assign w_err_addr = (state_q == c_B) ? w_burst_addr : w_beat_addr;

    // IDs are fixed at zero and never checked; low base bits are discarded.
    assign w_unused   = ^{cfg_base_i[3:0], txbid_i, txrid_i};

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (start_i) begin
                    state_d = (cfg_num_beats_i == '0) ? c_FIN : c_AW;
                end
            end
            c_AW: begin
                if (txawready_i) begin
                    state_d = c_W;
                end
            end
            c_W: begin
                if (txwready_i && w_last_beat) begin
                    state_d = c_B;
                end
            end
            c_B: begin
                if (txbvalid_i) begin
                    state_d = w_more ? c_AW : c_AR;
                end
            end
            c_AR: begin
                if (txarready_i) begin
                    state_d = c_R;
                end
            end
            c_R: begin
                if (txrvalid_i && w_last_beat) begin
                    state_d = w_more ? c_AR : c_FIN;
                end
            end
            c_FIN: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode (valids follow state so reset drops them at once)
    // ------------------------------------------------------------------------
    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        txawvalid_o = 1'b0;
        txwvalid_o  = 1'b0;
        txbready_o  = 1'b0;
        txarvalid_o = 1'b0;
        txrready_o  = 1'b0;
        case (state_q)
            c_AW: begin
                busy_o      = 1'b1;
                txawvalid_o = 1'b1;
            end
            c_W: begin
                busy_o      = 1'b1;
                txwvalid_o  = 1'b1;
            end
            c_B: begin
                busy_o      = 1'b1;
                txbready_o  = 1'b1;
            end
            c_AR: begin
                busy_o      = 1'b1;
                txarvalid_o = 1'b1;
            end
            c_R: begin
                busy_o      = 1'b1;
                txrready_o  = 1'b1;
            end
            c_FIN: begin
                busy_o      = 1'b1;
                done_o      = 1'b1;
            end
            default: begin
                busy_o      = 1'b0;
            end
        endcase
    end

    // Payload is zeroed whenever its channel is idle, so every output reads
    // zero in reset. While valid is high the fields depend only on counters
    // that move on handshakes, so they stay stable under back-pressure.
    assign txawid_o    = '0;
    assign txawaddr_o  = txawvalid_o ? w_burst_addr : '0;
    assign txawlen_o   = txawvalid_o ? 8'(w_burst - c_ONE) : 8'h0;
    assign txawsize_o  = txawvalid_o ? c_SIZE_16B : 3'd0;
    assign txawburst_o = txawvalid_o ? c_INCR : 2'b00;

    assign txwdata_o   = txwvalid_o ? w_pattern : '0;
    assign txwstrb_o   = txwvalid_o ? '1 : '0;
    assign txwlast_o   = txwvalid_o && w_last_beat;

    assign txarid_o    = '0;
    assign txaraddr_o  = txarvalid_o ? w_burst_addr : '0;
    assign txarlen_o   = txarvalid_o ? 8'(w_burst - c_ONE) : 8'h0;
    assign txarsize_o  = txarvalid_o ? c_SIZE_16B : 3'd0;
    assign txarburst_o = txarvalid_o ? c_INCR : 2'b00;

    // pass is live during the done cycle and then held by pass_q.
    assign pass_o            = (state_q == c_FIN) ? (err_q == '0) : pass_q;
    assign err_count_o       = err_q;
    assign first_fail_addr_o = ffa_q;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            num_q    <= '0;
            seed_q   <= '0;
            issued_q <= '0;
            beat_q   <= '0;
            err_q    <= '0;
            ffa_q    <= '0;
            pass_q   <= 1'b0;
`ifdef TIP_HELLO_BIST_LFSR_EN
            lfsr_q   <= '0;
`endif
        end else begin
            if (w_start) begin
                base_q   <= {cfg_base_i[BW_ADDR-1:4], 4'h0};
                num_q    <= cfg_num_beats_i;
                issued_q <= '0;
                beat_q   <= '0;
                err_q    <= '0;
                ffa_q    <= '0;
                pass_q   <= 1'b0;
`ifdef TIP_HELLO_BIST_LFSR_EN
                // An all-zero state would lock the LFSR, so seed 0 becomes 1.
                seed_q   <= (cfg_seed_i == 32'h0) ? 32'h1 : cfg_seed_i;
                lfsr_q   <= (cfg_seed_i == 32'h0) ? 32'h1 : cfg_seed_i;
`else
                seed_q   <= cfg_seed_i;
`endif
            end

            if (w_w_hs || w_r_hs) begin
                beat_q <= w_last_beat ? '0 : (beat_q + c_ONE);
`ifdef TIP_HELLO_BIST_LFSR_EN
                lfsr_q <= w_lfsr_next;
`endif
            end

            if (w_r_hs && w_last_beat) begin
                issued_q <= issued_q + w_burst;
            end

            // The last write response rewinds the beat index (and pattern
            // generator) so the read phase regenerates the same sequence.
            if (w_b_hs) begin
                if (w_more) begin
                    issued_q <= issued_q + w_burst;
                end else begin
                    issued_q <= '0;
`ifdef TIP_HELLO_BIST_LFSR_EN
                    lfsr_q   <= seed_q;
`endif
                end
            end

            if (w_err) begin
                if (err_q != '1) begin
                    err_q <= err_q + c_ONE;
                end
                if (err_q == '0) begin
                    ffa_q <= w_err_addr;
                end
            end

            if (state_q == c_FIN) begin
                pass_q <= (err_q == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tip_hello_sram_bist_axi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tip_hello_sram_bist_axi
// Purpose  : Self-checking bench for tip_hello_sram_bist_axi with a small
//            behavioural 128-bit SRAM AXI slave (optional random stalls,
//            optional single-word corruption before the read phase).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tip_hello_sram_bist_axi;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [31:0]  cfg_base_i;
    logic [15:0]  cfg_num_beats_i;
    logic [31:0]  cfg_seed_i;
    logic         busy_o, done_o, pass_o;
    logic [15:0]  err_count_o;
    logic [31:0]  first_fail_addr_o;

    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [3:0]   awid, arid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;

    always #5 clk = ~clk;

    tip_hello_sram_bist_axi dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start_i),
        .cfg_base_i        (cfg_base_i),
        .cfg_num_beats_i   (cfg_num_beats_i),
        .cfg_seed_i        (cfg_seed_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .pass_o            (pass_o),
        .err_count_o       (err_count_o),
        .first_fail_addr_o (first_fail_addr_o),
        .txawvalid_o       (awvalid),
        .txawready_i       (awready),
        .txawid_o          (awid),
        .txawaddr_o        (awaddr),
        .txawlen_o         (awlen),
        .txawsize_o        (awsize),
        .txawburst_o       (awburst),
        .txwvalid_o        (wvalid),
        .txwready_i        (wready),
        .txwdata_o         (wdata),
        .txwstrb_o         (wstrb),
        .txwlast_o         (wlast),
        .txbvalid_i        (bvalid),
        .txbready_o        (bready),
        .txbid_i           (4'h0),
        .txbresp_i         (2'b00),
        .txarvalid_o       (arvalid),
        .txarready_i       (arready),
        .txarid_o          (arid),
        .txaraddr_o        (araddr),
        .txarlen_o         (arlen),
        .txarsize_o        (arsize),
        .txarburst_o       (arburst),
        .txrvalid_i        (rvalid),
        .txrready_o        (rready),
        .txrid_i           (4'h0),
        .txrdata_i         (rdata),
        .txrresp_i         (2'b00),
        .txrlast_i         (rlast)
    );

    // ------------------------------------------------------------------------
    // Scoreboard counters and checking task
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference pattern, written from the pattern definition.
    function automatic logic [127:0] exp_word(input logic [31:0] seed, input int k);
        logic [31:0] l;
`ifdef TIP_HELLO_BIST_LFSR_EN
        l = (seed == 32'h0) ? 32'h1 : seed;
        for (int i = 0; i < k; i++) begin
            l = l[31] ? ({l[30:0], 1'b0} ^ 32'h0040_0007) : {l[30:0], 1'b0};
        end
`else
        l = seed ^ 32'(k);
`endif
        return {4{l}};
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural SRAM slave
    // ------------------------------------------------------------------------
    logic         stall_en;
    logic         corrupt_en;
    logic [9:0]   corrupt_idx;
    logic [31:0]  cur_base;
    logic [31:0]  cur_seed;

    logic [127:0] mem [0:1023];
    logic         w_act, r_act;
    logic [9:0]   w_idx, r_idx;
    logic [7:0]   w_cnt, w_len, r_cnt, r_len;
    logic         aw_stall, w_stall, ar_stall;
    logic [31:0]  aw_hold_addr, ar_hold_addr;
    logic [7:0]   aw_hold_len, ar_hold_len;
    logic [127:0] w_hold_data;
    logic         w_hold_last;

    logic [31:0]  aw_addr_log[$];
    logic [7:0]   aw_len_log[$];
    logic [31:0]  ar_addr_log[$];
    logic [7:0]   ar_len_log[$];
    logic [127:0] w_data_log[$];
    int           wlast_log[$];
    int           wbeats_total = 0;
    int           wdata_bad    = 0;
    int           wlast_bad    = 0;
    int           stab_bad     = 0;

    assign rdata = mem[10'(r_idx + 10'(r_cnt))];
    assign rlast = r_act && (r_cnt == r_len);

    function automatic logic rnd();
        return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
            arready <= 1'b0; rvalid <= 1'b0;
            w_act <= 1'b0; r_act <= 1'b0;
            w_idx <= '0; r_idx <= '0; w_cnt <= '0; r_cnt <= '0;
            w_len <= '0; r_len <= '0;
            aw_stall <= 1'b0; w_stall <= 1'b0; ar_stall <= 1'b0;
        end else begin
            // payload stability while the master is back-pressured
            if (aw_stall && !(awvalid && awaddr == aw_hold_addr && awlen == aw_hold_len)) stab_bad++;
            if (ar_stall && !(arvalid && araddr == ar_hold_addr && arlen == ar_hold_len)) stab_bad++;
            if (w_stall  && !(wvalid && wdata == w_hold_data && wlast == w_hold_last)) stab_bad++;
            aw_stall <= awvalid && !awready; aw_hold_addr <= awaddr; aw_hold_len <= awlen;
            ar_stall <= arvalid && !arready; ar_hold_addr <= araddr; ar_hold_len <= arlen;
            w_stall  <= wvalid && !wready;   w_hold_data  <= wdata;  w_hold_last <= wlast;

            // write address
            if (awvalid && awready) begin
                aw_addr_log.push_back(awaddr);
                aw_len_log.push_back(awlen);
                w_act   <= 1'b1;
                w_idx   <= awaddr[13:4];
                w_cnt   <= '0;
                w_len   <= awlen;
                awready <= 1'b0;
                wready  <= rnd();
            end else begin
                awready <= !w_act && !bvalid && rnd();
            end

            // write data
            if (wvalid && wready && w_act) begin
                mem[10'(w_idx + 10'(w_cnt))] <= wdata;
                wbeats_total++;
                w_data_log.push_back(wdata);
                if (wlast) wlast_log.push_back(wbeats_total);
                if (wlast != (w_cnt == w_len)) wlast_bad++;
                if (wdata != exp_word(cur_seed, int'(10'(w_idx + 10'(w_cnt) - cur_base[13:4]))))
                    wdata_bad++;
                if (w_cnt == w_len) begin
                    w_act  <= 1'b0;
                    wready <= 1'b0;
                    bvalid <= 1'b1;
                end else begin
                    w_cnt  <= w_cnt + 8'd1;
                    wready <= rnd();
                end
            end else if (w_act) begin
                wready <= rnd();
            end

            if (bvalid && bready) bvalid <= 1'b0;

            // read address (optionally corrupt one word before the read)
            if (arvalid && arready) begin
                ar_addr_log.push_back(araddr);
                ar_len_log.push_back(arlen);
                r_act   <= 1'b1;
                r_idx   <= araddr[13:4];
                r_cnt   <= '0;
                r_len   <= arlen;
                arready <= 1'b0;
                rvalid  <= 1'b0;
                if (corrupt_en) mem[corrupt_idx] <= mem[corrupt_idx] ^ 128'h1;
            end else begin
                arready <= !r_act && rnd();
                if (rvalid && rready) begin
                    if (r_cnt == r_len) begin
                        r_act  <= 1'b0;
                        rvalid <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + 8'd1;
                        rvalid <= rnd();
                    end
                end else if (r_act) begin
                    rvalid <= rvalid | rnd();
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic run(input logic [31:0] base, input logic [15:0] n,
                       input logic [31:0] seed, output int cycles, output logic got_done);
        @(negedge clk);
        cur_base        = base;
        cur_seed        = seed;
        cfg_base_i      = base;
        cfg_num_beats_i = n;
        cfg_seed_i      = seed;
        start_i         = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cycles  = 1;
        while (!done_o && cycles < 4000) begin
            @(negedge clk);
            cycles++;
        end
        got_done = done_o;
    endtask

    int          cyc, aw0, ar0, wl0, wb0, wd0, wbad0, lbad0, sbad0;
    logic        dn;
    logic [31:0] t1_addr [3] = '{32'h000, 32'h100, 32'h200};
    logic [7:0]  t1_len  [3] = '{8'd15, 8'd15, 8'd7};

    initial begin
        rst = 1'b1; start_i = 1'b0;
        cfg_base_i = '0; cfg_num_beats_i = '0; cfg_seed_i = '0;
        cur_base = '0; cur_seed = '0;
        stall_en = 1'b0; corrupt_en = 1'b0; corrupt_idx = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  busy_o, 0);
        check_eq("rst_done",  done_o, 0);
        check_eq("rst_pass",  pass_o, 0);
        check_eq("rst_err",   err_count_o, 0);
        check_eq("rst_ffa",   first_fail_addr_o, 0);
        check_eq("rst_valid", {awvalid, wvalid, arvalid, bready, rready}, 0);
        rst = 1'b0;

        // T1: 40 beats, bursts of 16/16/8, zero-wait
        aw0 = aw_addr_log.size(); ar0 = ar_addr_log.size(); wd0 = w_data_log.size();
        wbad0 = wdata_bad; lbad0 = wlast_bad; sbad0 = stab_bad;
        run(32'h0, 16'd40, 32'hA5A5_0000, cyc, dn);
        check_eq("t1_done", dn, 1);
        check_eq("t1_pass", pass_o, 1);
        check_eq("t1_err",  err_count_o, 0);
        check_eq("t1_aw_n", aw_addr_log.size() - aw0, 3);
        check_eq("t1_ar_n", ar_addr_log.size() - ar0, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("t1_awaddr", aw_addr_log[aw0+i], t1_addr[i]);
            check_eq("t1_awlen",  aw_len_log[aw0+i],  t1_len[i]);
            check_eq("t1_araddr", ar_addr_log[ar0+i], t1_addr[i]);
            check_eq("t1_arlen",  ar_len_log[ar0+i],  t1_len[i]);
        end
`ifndef TIP_HELLO_BIST_LFSR_EN
        check_eq("t1_wdata0",  w_data_log[wd0],    {4{32'hA5A5_0000}});
        check_eq("t1_wdata1",  w_data_log[wd0+1],  {4{32'hA5A5_0001}});
        check_eq("t1_wdata16", w_data_log[wd0+16], {4{32'hA5A5_0010}});
`endif
        check_eq("t1_wdata_all", wdata_bad - wbad0, 0);
        check_eq("t1_wlast",     wlast_bad - lbad0, 0);
        @(negedge clk);
        check_eq("t1_busy_after", busy_o, 0);
        check_eq("t1_done_pulse", done_o, 0);
        check_eq("t1_pass_hold",  pass_o, 1);

        // T2: zero beats -> done on the next cycle, no traffic
        aw0 = aw_addr_log.size(); ar0 = ar_addr_log.size();
        run(32'h1000, 16'd0, 32'h1234_5678, cyc, dn);
        check_eq("t2_done",    dn, 1);
        check_eq("t2_latency", cyc, 1);
        check_eq("t2_pass",    pass_o, 1);
        check_eq("t2_traffic", (aw_addr_log.size() - aw0) + (ar_addr_log.size() - ar0), 0);

        // T3: word at 0x50 corrupted between write and read
        corrupt_en = 1'b1; corrupt_idx = 10'd5;
        run(32'h0, 16'd16, 32'h1357_9BDF, cyc, dn);
        corrupt_en = 1'b0;
        check_eq("t3_done", dn, 1);
        check_eq("t3_err",  err_count_o, 1);
        check_eq("t3_ffa",  first_fail_addr_o, 32'h50);
        check_eq("t3_pass", pass_o, 0);
        @(negedge clk);
        check_eq("t3_pass_hold", pass_o, 0);

        // T4: random stalls, 33 beats
        stall_en = 1'b1;
        wl0 = wlast_log.size(); wb0 = wbeats_total;
        wbad0 = wdata_bad; lbad0 = wlast_bad; sbad0 = stab_bad;
        run(32'h400, 16'd33, 32'hDEAD_BEEF, cyc, dn);
        stall_en = 1'b0;
        check_eq("t4_done",   dn, 1);
        check_eq("t4_pass",   pass_o, 1);
        check_eq("t4_err",    err_count_o, 0);
        check_eq("t4_wlast_n", wlast_log.size() - wl0, 3);
        if (wlast_log.size() - wl0 == 3) begin
            check_eq("t4_wlast_a", wlast_log[wl0]   - wb0, 16);
            check_eq("t4_wlast_b", wlast_log[wl0+1] - wb0, 32);
            check_eq("t4_wlast_c", wlast_log[wl0+2] - wb0, 33);
        end
        check_eq("t4_stable", stab_bad - sbad0, 0);
        check_eq("t4_wdata",  wdata_bad - wbad0, 0);
        check_eq("t4_wlastok", wlast_bad - lbad0, 0);

        // T5: reset during the third write beat, then a full rerun
        wb0 = wbeats_total;
        @(negedge clk);
        cur_base = 32'h0; cur_seed = 32'h0F0F_0F0F;
        cfg_base_i = 32'h0; cfg_num_beats_i = 16'd40; cfg_seed_i = 32'h0F0F_0F0F;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (!((wbeats_total - wb0 == 2) && wvalid) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("t5_reach_beat3", cyc < 200, 1);
        rst = 1'b1;
        #1;
        check_eq("t5_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check_eq("t5_status", {busy_o, done_o, pass_o}, 0);
        check_eq("t5_wdata",  wdata, 0);
        check_eq("t5_err",    err_count_o, 0);
        @(negedge clk);
        rst = 1'b0;
        run(32'h0, 16'd40, 32'h0F0F_0F0F, cyc, dn);
        check_eq("t5_done", dn, 1);
        check_eq("t5_pass", pass_o, 1);
        check_eq("t5_err2", err_count_o, 0);

`ifdef TIP_HELLO_BIST_LFSR_EN
        // T6: LFSR seed 0 is replaced by 1; LFSR(1) = 2
        wd0 = w_data_log.size();
        run(32'h0, 16'd20, 32'h0, cyc, dn);
        check_eq("t6_done",   dn, 1);
        check_eq("t6_wdata0", w_data_log[wd0],   {4{32'h0000_0001}});
        check_eq("t6_wdata1", w_data_log[wd0+1], {4{32'h0000_0002}});
        check_eq("t6_pass",   pass_o, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
